// File: rtl/sync_gray_w2r.sv
// Write-pointer synchroniser for the async FIFO read side: N-flop gray chain, binary conversion,
// per-cycle advance and occupancy. Optional sticky multi-bit gray check via SYNC_GRAY_CHECK_EN.
module sync_gray_w2r #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic [ADDRSIZE:0] wr_grayptr,
  input  logic [ADDRSIZE:0] rd_binptr,
  output logic [ADDRSIZE:0] rq_wr_grayptr,
  output logic [ADDRSIZE:0] rq_wr_binptr,
  output logic [ADDRSIZE:0] rq_wr_delta,
  output logic              rq_wr_adv,
  output logic [ADDRSIZE:0] rd_count,
  output logic              sync_ready,
  output logic              gray_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(SYNC_STAGES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_gray_w2r: SYNC_STAGES must be in 2..4");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] sync_r [SYNC_STAGES];
  logic [PW-1:0] bin_r;
  logic [PW-1:0] delta_r;
  logic          adv_r;
  logic [CW-1:0] cnt_r;
  logic          ready_r;
  logic [PW-1:0] bin_next_s;
  logic [PW-1:0] delta_s;

  assign bin_next_s = gray2bin(sync_r[SYNC_STAGES-1]);
  assign delta_s    = bin_next_s - bin_r;

  // Synchroniser chain: stage 0 samples the asynchronous write pointer
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= wr_grayptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Settle counter: ready once the first post-reset value has reached the binary register
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cnt_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      if (cnt_r != CNT_DONE) cnt_r <= cnt_r + CW'(1);
      ready_r <= ready_r | (cnt_r == CNT_DONE);
    end
  end

  // Binary pointer always loads; advance is suppressed until settled so the first value is absorbed
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      bin_r   <= '0;
      delta_r <= '0;
      adv_r   <= 1'b0;
    end else begin
      bin_r <= bin_next_s;
      if (ready_r) begin
        delta_r <= delta_s;
        adv_r   <= (delta_s != '0);
      end else begin
        delta_r <= '0;
        adv_r   <= 1'b0;
      end
    end
  end

`ifdef SYNC_GRAY_CHECK_EN
  function automatic logic multi_bit(input logic [PW-1:0] x);
    return (x & (x - PW'(1))) != '0;
  endfunction

  logic err_r;

  // Sticky flag for a gray step that changes more than one bit between the last two stages
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (ready_r & multi_bit(sync_r[SYNC_STAGES-2] ^ sync_r[SYNC_STAGES-1]));
    end
  end

  assign gray_err = err_r;
`else
  assign gray_err = 1'b0;
`endif

  assign rq_wr_grayptr = sync_r[SYNC_STAGES-1];
  assign rq_wr_binptr  = bin_r;
  assign rq_wr_delta   = delta_r;
  assign rq_wr_adv     = adv_r;
  assign sync_ready    = ready_r;
  assign rd_count      = bin_r - rd_binptr;

endmodule
